serial_slave_responder: RTL and testbench
=========================================

// Module: serial_slave_responder
// PURPOSE
//  Responder end of the bit-serial system bus. Sits behind one arbiter slave
//  channel (slave 1/2/3 or bus bridge), holding a local DATA_WIDTH x 2**ADDR_WIDTH
//  memory. It deserialises address/write data from wr_bus and serialises read
//  data onto rd_bus using the master_valid/slave_ready and slave_valid/master_ready
//  handshake pairs. The arbiter has already stripped the high decode bits.
// PARAMETERS
//  ADDR_WIDTH    12  local address bits received per frame (11 for slave 1, 14 for bridge)
//  DATA_WIDTH    8   data bits per transfer
//  READ_LATENCY  2   cycles (>=1) between last address bit and first read data bit
// PORTS
//  clk           in   1  system clock, all state on posedge
//  rstn          in   1  asynchronous active-low reset
//  mode          in   1  1 = write, 0 = read; sampled with first address bit only
//  wr_bus        in   1  serial address/write-data bit from master, LSB first
//  master_valid  in   1  wr_bus bit valid this cycle
//  slave_ready   out  1  responder can accept a wr_bus bit this cycle
//  rd_bus        out  1  serial read-data bit to master, LSB first
//  slave_valid   out  1  rd_bus bit valid this cycle
//  master_ready  in   1  master accepts rd_bus bit this cycle
// BEHAVIOUR
//  - Reset: state IDLE, slave_ready=0, slave_valid=0, rd_bus=0, counters/shift regs 0.
//    slave_ready rises on first posedge after rstn deasserts. Memory not reset.
//  - All outputs registered. Bit accepted on posedge where master_valid & slave_ready.
//  - Frame: ADDR_WIDTH address bits, then (write only) DATA_WIDTH data bits, LSB first.
//  - FSM:
//    IDLE : slave_ready=1. Accepted bit -> addr[0], latch mode, cnt=1, -> ADDR
//           (-> WDATA/RWAIT directly if ADDR_WIDTH==1).
//    ADDR : accepted bit -> addr[cnt]; on bit ADDR_WIDTH-1: mode ? WDATA : RWAIT.
//    WDATA: accepted bit -> wdata[cnt]; on bit DATA_WIDTH-1 -> WRITE, slave_ready=0.
//    WRITE: one cycle, mem[addr]<=wdata, slave_ready=1 at exit, -> IDLE.
//    RWAIT: slave_ready=0; counts READ_LATENCY cycles; loads mem[addr] into shreg;
//           -> RDATA with slave_valid=1, rd_bus=shreg[0].
//    RDATA: on master_ready: shift; after DATA_WIDTH-th accepted bit slave_valid=0,
//           rd_bus=0, slave_ready=1, -> IDLE. master_ready low: rd_bus/slave_valid hold.
//  - Read timing: last address bit accepted at edge N -> slave_valid=1 from edge
//    N+READ_LATENCY; read transfer takes >= DATA_WIDTH cycles.
//  - master_valid low mid-frame = stall, never abort; bit counters hold.
//  - wr_bus/master_valid ignored while slave_ready=0 (WRITE, RWAIT, RDATA).
//  - master_ready ignored outside RDATA. mode ignored after first address bit.
//  - Address wrap: all ADDR_WIDTH bits used; 0 and 2**ADDR_WIDTH-1 valid, no aliasing.
//  - Reset mid-operation: frame abandoned immediately; a write not yet in WRITE
//    never touches memory; outputs return to reset values asynchronously.
//  - Back-to-back: new frame may start the cycle after return to IDLE.
// TESTING (ADDR_WIDTH=11, DATA_WIDTH=8, READ_LATENCY=2)
//  1 write 0x5A @0x123, then read 0x123 -> slave_valid 8 cycles, rd_bus 0,1,0,1,1,0,1,0;
//    slave_valid rises exactly 2 edges after last address bit.
//  2 write 0xC3 @0x0F0 with master_valid low 3 cycles mid-address, 2 mid-data
//    -> read 0x0F0 returns 0xC3; slave_ready never drops during stalls.
//  3 read with master_ready low 4 cycles after 3rd bit -> rd_bus/slave_valid held,
//    full byte 0xC3 delivered, slave_valid low after 8th accepted bit.
//  4 write 0xFF @0x7FF, 0x01 @0x000 back-to-back -> reads return 0xFF and 0x01.
//  5 write 0x11 @0x200; start write 0x99 @0x200, assert rstn low after 4 data bits
//    -> outputs reset at once; read 0x200 after reset returns 0x11.
//  6 wr_bus toggling with master_valid=1 during RWAIT/RDATA -> ignored, read data correct.

Source files
------------

// File: rtl/serial_slave_responder_if.sv
// Bit-serial channel between an arbiter slave port and a responder:
// address/write data flows on wr_bus, read data returns on rd_bus.
interface serial_slave_responder_if;
   logic mode;
   logic wr_bus;
   logic master_valid;
   logic slave_ready;
   logic rd_bus;
   logic slave_valid;
   logic master_ready;

   modport master (
      output mode, wr_bus, master_valid, master_ready,
      input  slave_ready, rd_bus, slave_valid
   );

   modport slave (
      input  mode, wr_bus, master_valid, master_ready,
      output slave_ready, rd_bus, slave_valid
   );
endinterface

// File: rtl/serial_slave_responder.sv
// Responder end of the bit-serial bus: deserialises address/write data into a
// local memory and serialises read data back, LSB first on both directions.
module serial_slave_responder #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   serial_slave_responder_if.slave  bus
);
   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WDATA = 3'd2,
      WRITE = 3'd3,
      RWAIT = 3'd4,
      RDATA = 3'd5
   } state_t;

   state_t                  state_r, state_s;
   logic [CNT_W-1:0]        cnt_r, cnt_s;
   logic [LAT_W-1:0]        lat_r, lat_s;
   logic                    mode_r, mode_s;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_s, addr_shift_s;
   logic [DATA_WIDTH-1:0]   wdata_r, wdata_s, wdata_shift_s;
   logic [DATA_WIDTH-1:0]   shreg_r, shreg_s, shreg_shift_s;
   logic                    slave_ready_r, slave_ready_s;
   logic                    slave_valid_r, slave_valid_s;
   logic                    rd_bus_r, rd_bus_s;
   logic                    bit_in_s, rd_ack_s, mode_eff_s;
   logic [DATA_WIDTH-1:0]   mem_word_s;
   logic [DATA_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];

   // Next-state and next-output logic for the frame FSM.
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      lat_s         = lat_r;
      mode_s        = mode_r;
      addr_s        = addr_r;
      wdata_s       = wdata_r;
      shreg_s       = shreg_r;
      slave_ready_s = slave_ready_r;
      slave_valid_s = slave_valid_r;
      rd_bus_s      = rd_bus_r;

      bit_in_s   = bus.master_valid & slave_ready_r;
      rd_ack_s   = bus.master_ready & slave_valid_r;
      mode_eff_s = (state_r == IDLE) ? bus.mode : mode_r;
      mem_word_s = mem[addr_r];

      // LSB-first shift-in: after the full frame the first bit sits at index 0.
      addr_shift_s                 = addr_r >> 1;
      addr_shift_s[ADDR_WIDTH-1]   = bus.wr_bus;
      wdata_shift_s                = wdata_r >> 1;
      wdata_shift_s[DATA_WIDTH-1]  = bus.wr_bus;
      shreg_shift_s                = shreg_r >> 1;

      case (state_r)
         IDLE, ADDR: begin
            slave_ready_s = 1'b1;
            if (bit_in_s) begin
               addr_s = addr_shift_s;
               mode_s = mode_eff_s;
               if (cnt_r == ADDR_LAST) begin
                  cnt_s = '0;
                  lat_s = '0;
                  if (mode_eff_s) begin
                     state_s = WDATA;
                  end else begin
                     state_s       = RWAIT;
                     slave_ready_s = 1'b0;
                  end
               end else begin
                  cnt_s   = cnt_r + 1'b1;
                  state_s = ADDR;
               end
            end else begin
               state_s = state_r;
            end
         end
         WDATA: begin
            slave_ready_s = 1'b1;
            if (bit_in_s) begin
               wdata_s = wdata_shift_s;
               if (cnt_r == DATA_LAST) begin
                  cnt_s         = '0;
                  state_s       = WRITE;
                  slave_ready_s = 1'b0;
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end else begin
               state_s = WDATA;
            end
         end
         WRITE: begin
            slave_ready_s = 1'b1;
            state_s       = IDLE;
         end
         RWAIT: begin
            slave_ready_s = 1'b0;
            if (lat_r == LAT_LAST) begin
               lat_s         = '0;
               cnt_s         = '0;
               shreg_s       = mem_word_s;
               rd_bus_s      = mem_word_s[0];
               slave_valid_s = 1'b1;
               state_s       = RDATA;
            end else begin
               lat_s = lat_r + 1'b1;
            end
         end
         RDATA: begin
            slave_ready_s = 1'b0;
            if (rd_ack_s) begin
               if (cnt_r == DATA_LAST) begin
                  cnt_s         = '0;
                  shreg_s       = '0;
                  rd_bus_s      = 1'b0;
                  slave_valid_s = 1'b0;
                  slave_ready_s = 1'b1;
                  state_s       = IDLE;
               end else begin
                  cnt_s    = cnt_r + 1'b1;
                  shreg_s  = shreg_shift_s;
                  rd_bus_s = shreg_shift_s[0];
               end
            end else begin
               state_s = RDATA;
            end
         end
         default: begin
            state_s       = IDLE;
            cnt_s         = '0;
            lat_s         = '0;
            slave_ready_s = 1'b0;
            slave_valid_s = 1'b0;
            rd_bus_s      = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         lat_r         <= '0;
         mode_r        <= 1'b0;
         addr_r        <= '0;
         wdata_r       <= '0;
         shreg_r       <= '0;
         slave_ready_r <= 1'b0;
         slave_valid_r <= 1'b0;
         rd_bus_r      <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         lat_r         <= lat_s;
         mode_r        <= mode_s;
         addr_r        <= addr_s;
         wdata_r       <= wdata_s;
         shreg_r       <= shreg_s;
         slave_ready_r <= slave_ready_s;
         slave_valid_r <= slave_valid_s;
         rd_bus_r      <= rd_bus_s;
      end
   end

   // Local storage, committed only in the single WRITE cycle and never reset.
   always_ff @(posedge clk) begin
      if (state_r == WRITE) begin
         mem[addr_r] <= wdata_r;
      end
   end

   assign bus.slave_ready = slave_ready_r;
   assign bus.slave_valid = slave_valid_r;
   assign bus.rd_bus      = rd_bus_r;
endmodule

// File: tb/tb_serial_slave_responder.sv
// Directed plus randomized bench for serial_slave_responder, checked against a
// byte-array memory model and bit-level timing expectations.
module tb_serial_slave_responder;
   localparam int AW = 11;
   localparam int DW = 8;
   localparam int RL = 2;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   errors = 0;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   serial_slave_responder_if bus_if ();

   serial_slave_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic m);
      int n;
      bus_if.wr_bus       = b;
      bus_if.mode         = m;
      bus_if.master_valid = 1'b1;
      n = 0;
      while (bus_if.slave_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("ready_for_bit", bus_if.slave_ready, 1);
      tick();
      bus_if.master_valid = 1'b0;
   endtask

   task automatic stall(input int n);
      for (int k = 0; k < n; k++) begin
         bus_if.master_valid = 1'b0;
         bus_if.wr_bus       = 1'($urandom);
         bus_if.mode         = 1'($urandom);
         tick();
         check("stall_ready_high", bus_if.slave_ready, 1);
      end
   endtask

   task automatic write_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input int a_at, input int a_n, input int d_at, input int d_n);
      for (int i = 0; i < AW; i++) begin
         if (i == a_at) stall(a_n);
         send_bit(addr[i], (i == 0) ? 1'b1 : 1'($urandom));
      end
      for (int i = 0; i < DW; i++) begin
         if (i == d_at) stall(d_n);
         send_bit(data[i], 1'($urandom));
      end
      check("write_cycle_ready_low", bus_if.slave_ready, 0);
      tick();
      check("write_done_ready_high", bus_if.slave_ready, 1);
      ref_mem[addr] = data;
   endtask

   task automatic noise(input bit on);
      if (on) begin
         bus_if.master_valid = 1'b1;
         bus_if.wr_bus       = 1'($urandom);
         bus_if.mode         = 1'($urandom);
      end
   endtask

   task automatic read_frame(input logic [AW-1:0] addr, input int mr_at, input int mr_n,
                             input bit nz);
      logic [DW-1:0] exp;
      exp = ref_mem[addr];
      for (int i = 0; i < AW; i++) begin
         send_bit(addr[i], (i == 0) ? 1'b0 : 1'($urandom));
      end
      // last address bit accepted on the edge just passed
      noise(nz);
      bus_if.master_ready = nz ? 1'($urandom) : 1'b0;
      check("read_ready_low", bus_if.slave_ready, 0);
      check("read_valid_wait", bus_if.slave_valid, 0);
      for (int k = 1; k < RL; k++) begin
         tick();
         noise(nz);
         check("read_valid_early", bus_if.slave_valid, 0);
      end
      tick();
      noise(nz);
      check("read_valid_rise", bus_if.slave_valid, 1);
      bus_if.master_ready = 1'b1;
      for (int b = 0; b < DW; b++) begin
         check("read_bit", bus_if.rd_bus, exp[b]);
         check("read_valid_high", bus_if.slave_valid, 1);
         if (b == mr_at) begin
            bus_if.master_ready = 1'b0;
            for (int k = 0; k < mr_n; k++) begin
               tick();
               noise(nz);
               check("hold_bit", bus_if.rd_bus, exp[b]);
               check("hold_valid", bus_if.slave_valid, 1);
            end
            bus_if.master_ready = 1'b1;
         end
         tick();
         noise(nz);
      end
      bus_if.master_valid = 1'b0;
      bus_if.master_ready = 1'b0;
      check("read_end_valid_low", bus_if.slave_valid, 0);
      check("read_end_rd_low", bus_if.rd_bus, 0);
      check("read_end_ready_high", bus_if.slave_ready, 1);
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;

      rstn                = 1'b0;
      bus_if.mode         = 1'b0;
      bus_if.wr_bus       = 1'b0;
      bus_if.master_valid = 1'b0;
      bus_if.master_ready = 1'b0;
      repeat (3) tick();
      check("reset_ready", bus_if.slave_ready, 0);
      check("reset_valid", bus_if.slave_valid, 0);
      check("reset_rd_bus", bus_if.rd_bus, 0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("ready_before_first_edge", bus_if.slave_ready, 0);
      tick();
      check("ready_after_first_edge", bus_if.slave_ready, 1);

      // 1: plain write then read
      write_frame(11'h123, 8'h5A, -1, 0, -1, 0);
      read_frame(11'h123, -1, 0, 1'b0);

      // 2: stalls mid-address and mid-data
      write_frame(11'h0F0, 8'hC3, 5, 3, 4, 2);
      read_frame(11'h0F0, -1, 0, 1'b0);

      // 3: master_ready low for 4 cycles after the 3rd bit
      read_frame(11'h0F0, 3, 4, 1'b0);

      // 4: address extremes back to back
      write_frame(11'h7FF, 8'hFF, -1, 0, -1, 0);
      write_frame(11'h000, 8'h01, -1, 0, -1, 0);
      read_frame(11'h7FF, -1, 0, 1'b0);
      read_frame(11'h000, -1, 0, 1'b0);

      // 5: reset in the middle of a write
      write_frame(11'h200, 8'h11, -1, 0, -1, 0);
      pa = 11'h200;
      pd = 8'h99;
      for (int i = 0; i < AW; i++) send_bit(pa[i], (i == 0) ? 1'b1 : 1'($urandom));
      for (int i = 0; i < 4; i++) send_bit(pd[i], 1'($urandom));
      check("mid_write_ready", bus_if.slave_ready, 1);
      #2;
      rstn = 1'b0;
      #1;
      check("async_reset_ready", bus_if.slave_ready, 0);
      check("async_reset_valid", bus_if.slave_valid, 0);
      check("async_reset_rd_bus", bus_if.rd_bus, 0);
      repeat (2) tick();
      @(negedge clk);
      rstn = 1'b1;
      tick();
      read_frame(11'h200, -1, 0, 1'b0);

      // 6: wr_bus/master_valid activity during RWAIT/RDATA
      read_frame(11'h123, 2, 2, 1'b1);

      // randomized transactions against the memory model
      for (int t = 0; t < 8; t++) begin
         ra = AW'($urandom_range(0, (1 << AW) - 1));
         rd = DW'($urandom);
         write_frame(ra, rd, int'($urandom_range(1, AW - 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(1, DW - 1)), int'($urandom_range(0, 3)));
         read_frame(ra, int'($urandom_range(0, DW - 1)), int'($urandom_range(0, 3)),
                    1'($urandom));
      end
      read_frame(11'h7FF, -1, 0, 1'b0);
      read_frame(11'h000, -1, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
